// File: rtl/bus_arbiter16.sv
// bus_arbiter16: round-robin arbiter for a 16-way shared resource with bounded hold time
// and one turnaround cycle between grants.
module bus_arbiter16 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] REQ,
    input  logic        DONE,
    output logic [15:0] GNT,
    output logic [3:0]  SEL,
    output logic        BUSY,
    output logic        TIMEOUT
);
    typedef enum logic {IDLE, OWNED} state_t;

    state_t      state_q, state_d;
    logic [15:0] gnt_q, gnt_d;
    logic [3:0]  sel_q, sel_d, ptr_q, ptr_d, win, idx;
    logic [7:0]  hcnt_q, hcnt_d;
    logic        busy_q, busy_d, to_q, to_d, found, rel_done, rel_drop, rel_to;

    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr_q + 4'(i);
            if (!found && REQ[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign rel_done = DONE;
    assign rel_drop = ~REQ[sel_q];
    assign rel_to   = (MAX_HOLD != 0) && (hcnt_q == 8'(MAX_HOLD));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        busy_d  = busy_q;
        to_d    = 1'b0;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = OWNED;
                sel_d   = win;
                gnt_d   = 16'(1) << win;
                busy_d  = 1'b1;
                hcnt_d  = 8'd1;
            end
        end else if (rel_done || rel_drop || rel_to) begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            ptr_d   = sel_q + 4'd1;
            to_d    = rel_to && !rel_done && !rel_drop;
        end else begin
            hcnt_d = hcnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hcnt_q  <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    end

    assign GNT     = gnt_q;
    assign SEL     = sel_q;
    assign BUSY    = busy_q;
    assign TIMEOUT = to_q;
endmodule

// File: tb/tb_bus_arbiter16.sv
// tb_bus_arbiter16: cycle-level model of the arbiter compared every cycle, plus directed
// literal checks for reset, rotation, wrap, timeout, release causes and mid-tenure reset.
module tb_bus_arbiter16;
    localparam int MH = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] REQ = '0;
    logic        DONE = 1'b0;
    logic [15:0] GNT;
    logic [3:0]  SEL;
    logic        BUSY, TIMEOUT;

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    // Model: owner index (-1 when idle), priority pointer, hold count, last grantee.
    int m_own = -1, m_ptr = 0, m_hold = 0, m_sel = 0;
    bit m_to = 1'b0;

    bus_arbiter16 #(.MAX_HOLD(MH)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .DONE(DONE),
        .GNT(GNT), .SEL(SEL), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RST) begin
            m_own = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_own < 0) begin
                for (int k = 0; k < 16; k++) begin
                    int c;
                    c = (m_ptr + k) % 16;
                    if (m_own < 0 && REQ[c]) begin
                        m_own = c; m_sel = c; m_hold = 1;
                    end
                end
            end else begin
                bit d, dr, t;
                d  = DONE;
                dr = !REQ[m_own];
                t  = (MH != 0) && (m_hold == MH);
                if (d || dr || t) begin
                    m_to  = t && !d && !dr;
                    m_ptr = (m_own + 1) % 16;
                    m_own = -1;
                end else begin
                    m_hold++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (en) begin
            chk("model_gnt", GNT, (m_own < 0) ? 16'h0 : (16'h1 << m_own));
            chk("model_sel", 16'(SEL), 16'(m_sel));
            chk("model_busy", 16'(BUSY), 16'(m_own >= 0));
            chk("model_timeout", 16'(TIMEOUT), 16'(m_to));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        REQ = 16'hFFFF;
        tick();
        en = 1'b1;
        tick();
        chk("rst_gnt", GNT, 16'h0);
        chk("rst_sel", 16'(SEL), 16'h0);
        chk("rst_busy", 16'(BUSY), 16'h0);
        chk("rst_timeout", 16'(TIMEOUT), 16'h0);
        RST = 1'b0;
        tick();
        chk("first_gnt", GNT, 16'h0001);

        for (int i = 0; i < 16; i++) begin
            chk("rot_sel", 16'(SEL), 16'(i));
            DONE = 1'b1;
            tick();
            chk("rot_gap", 16'(BUSY), 16'h0);
            DONE = 1'b0;
            tick();
        end
        chk("rot_wrap", GNT, 16'h0001);

        RST = 1'b1; tick();
        RST = 1'b0; REQ = 16'h8001; tick();
        chk("wrap_g0", GNT, 16'h0001);
        DONE = 1'b1; tick(); DONE = 1'b0; tick();
        chk("wrap_g15", GNT, 16'h8000);
        DONE = 1'b1; tick(); DONE = 1'b0; tick();
        chk("wrap_g0b", GNT, 16'h0001);
        REQ = 16'h0; tick();
        DONE = 1'b1; tick(); DONE = 1'b0;
        chk("idle_done", 16'(BUSY), 16'h0);

        RST = 1'b1; tick();
        RST = 1'b0; REQ = 16'h0024; tick();
        for (int c = 0; c < MH; c++) begin
            chk("to_hold", GNT, 16'h0004);
            chk("to_low", 16'(TIMEOUT), 16'h0);
            tick();
        end
        chk("to_rel", GNT, 16'h0);
        chk("to_pulse", 16'(TIMEOUT), 16'h1);
        tick();
        chk("to_next", GNT, 16'h0020);
        chk("to_clear", 16'(TIMEOUT), 16'h0);

        tick(); tick(); tick();
        DONE = 1'b1; tick(); DONE = 1'b0;
        chk("sim_rel", GNT, 16'h0);
        chk("sim_to", 16'(TIMEOUT), 16'h0);
        tick();
        chk("drop_gnt", GNT, 16'h0004);
        tick();
        REQ = 16'h0020; tick();
        chk("drop_rel", GNT, 16'h0);
        chk("drop_to", 16'(TIMEOUT), 16'h0);
        tick();
        chk("drop_next", GNT, 16'h0020);

        RST = 1'b1; tick();
        RST = 1'b0; REQ = 16'h0200; tick();
        chk("mid_g9", GNT, 16'h0200);
        tick();
        RST = 1'b1; REQ = 16'h0300; tick();
        chk("mid_gnt", GNT, 16'h0);
        chk("mid_sel", 16'(SEL), 16'h0);
        RST = 1'b0; tick();
        chk("mid_g8", GNT, 16'h0100);
        chk("mid_sel8", 16'(SEL), 16'h8);
        REQ = 16'h0; tick(); tick();

        en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter16.md
# bus_arbiter16

Round-robin arbiter that shares one 16-bit CPU resource (the internal data bus or the register-file write port) among up to 16 requesters. It owns the 4-bit select that drives the 1-to-16 demultiplexer on that resource, and it issues a one-hot grant equal to that demultiplexer's decode. It also enforces a bounded hold time per grant and inserts one turnaround cycle between grants. It sits between the control unit's request lines and the shared datapath.

## Interface
Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles per tenure (1..255); 0 disables the timeout.

Ports:
- CLK  input  1  single system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
- REQ  input  16  request lines, one per requester; level-sensitive.
- DONE  input  1  holder's release strobe, sampled only while BUSY=1.
- GNT  output  16  one-hot grant, registered; all zero when idle.
- SEL  output  4  index of the current or last grantee; drives the demux select.
- BUSY  output  1  high while any GNT bit is high.
- TIMEOUT  output  1  one-cycle pulse, registered: the previous tenure was force-released by MAX_HOLD.

## Operation
- State register, 2 states: IDLE and OWNED.
- Priority pointer PTR (4 bits) holds the highest-priority index. Search order is PTR, PTR+1, …, 15, 0, …, PTR-1, with wrap modulo 16.
- Hold counter HCNT (8 bits) counts grant cycles of the current tenure.

IDLE:
- If REQ≠0: pick the first set bit in search order as W. Next edge: SEL←W, GNT←1<<W, BUSY←1, HCNT←1, state→OWNED.
- If REQ=0: remain in IDLE. GNT, BUSY and SEL hold.

OWNED, evaluated each cycle:
- rel_done = DONE.
- rel_drop = ~REQ[SEL].
- rel_to = (MAX_HOLD≠0) & (HCNT==MAX_HOLD).
- If any release term is true, next edge: GNT←0, BUSY←0, PTR←SEL+1 (mod 16, so 15 wraps to 0), state→IDLE. SEL holds its value.
- TIMEOUT←1 on that edge only if rel_to & ~rel_done & ~rel_drop. Otherwise TIMEOUT←0.
- If no release term is true: HCNT←HCNT+1. Grant holds.
- Changes on other REQ bits during OWNED are ignored. No preemption.

TIMEOUT is 0 on every edge except the release edge described above.

Reset values:
- GNT=0, SEL=0, BUSY=0, TIMEOUT=0.
- PTR=0, HCNT=0, state=IDLE.

Invariants:
- GNT is always zero or one-hot.
- When BUSY=1, GNT equals the 1-to-16 decode of SEL.

## Timing
- Grant latency: REQ sampled at edge n in IDLE gives GNT valid after edge n+1, i.e. one cycle.
- Release: a release term sampled at edge m gives GNT=0 after edge m+1.
- Turnaround: at least one full cycle with BUSY=0 between consecutive tenures, even with pending requests. Back-to-back grant spacing is therefore 2 edges.
- Maximum tenure is MAX_HOLD cycles of GNT high.
- Worst-case wait for a continuously requesting line is 15 × (MAX_HOLD+1) cycles.
- Simultaneous release terms: any combination releases. TIMEOUT is set only when the timeout is the sole cause.
- A requester released by timeout that keeps REQ high rejoins the rotation behind all others, because PTR has advanced past it.
- RST asserted mid-tenure: GNT=0, BUSY=0 and PTR=0 after that edge. Any grant the same edge would have issued is suppressed.
- RST dominates all other inputs.
- DONE while in IDLE is ignored.

## Test plan
- Reset: RST=1 for 2 cycles with REQ=16'hFFFF -> GNT=0, SEL=0, BUSY=0, TIMEOUT=0. Release RST -> GNT=16'h0001 one cycle later.
- Rotation: REQ=16'hFFFF, DONE pulsed on each tenure's first grant cycle -> SEL sequence 0,1,2,…,15,0, with exactly one BUSY=0 cycle between grants.
- Wrap: after reset, REQ=16'h8001; grant 0, DONE -> next grant 15 (GNT=16'h8000), DONE -> next grant 0.
- Timeout: MAX_HOLD=4, REQ=16'h0024, no DONE -> GNT=16'h0004 for exactly 4 cycles, TIMEOUT=1 for one cycle, then GNT=16'h0020 after the turnaround cycle.
- Simultaneous / drop: MAX_HOLD=4, DONE=1 on 4th grant cycle -> release with TIMEOUT=0. REQ[SEL] dropped on grant cycle 2 -> GNT=0 next edge, TIMEOUT=0.
- Reset mid-tenure: grant held on index 9, RST pulsed -> GNT=0, SEL=0 next edge. With REQ=16'h0300 afterwards -> grant index 8 (PTR back to 0).
